// File: rtl/shared_counter_pkg.sv
// Shared types and default sizing for the shared counter arbiter.
// Opcode and arbiter state encodings are used by the RTL and the bench alike.
package shared_counter_pkg;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_LOCK_MAX = 8;

    typedef enum logic [1:0] {
        OP_INC   = 2'b00,
        OP_ADD   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request at or above
// i_ptr, wrapping around, and reports the winner as one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx
);

    int w_k;

    // Scan from the farthest offset down so the nearest request to i_ptr wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_k     = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_k = (int'(i_ptr) + off) % NREQ;
            if (i_req[w_k]) begin
                o_grant      = '0;
                o_grant[w_k] = 1'b1;
                o_idx        = PW'(w_k);
            end
        end
    end

endmodule

// File: rtl/shared_counter_arbiter.sv
// Shares one WIDTH-bit counter between NREQ requesters with round-robin
// arbitration, a bounded ownership lock, and a one-cycle-late response.
module shared_counter_arbiter
    import shared_counter_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [WIDTH*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_value,
    output logic                     rsp_wrap,
    output logic [WIDTH-1:0]         count,
    output state_t                   dbg_state
);

    localparam int PW  = $clog2(NREQ);
    localparam int LCW = $clog2(LOCK_MAX) + 1;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic [LCW-1:0]   r_lock_cnt;
    logic [WIDTH-1:0] r_count;
    logic             r_rsp_valid;
    logic [PW-1:0]    r_rsp_id;
    logic [WIDTH-1:0] r_rsp_value;
    logic             r_rsp_wrap;

    logic [NREQ-1:0]  w_pick_req;
    logic [NREQ-1:0]  w_grant;
    logic [PW-1:0]    w_win;
    logic             w_xfer;
    op_t              w_op;
    logic [WIDTH-1:0] w_data;
    logic             w_lock;
    logic [WIDTH:0]   w_sum;
    logic             w_lock_expired;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + PW'(1);
    endfunction

    // Handshake: a command transfers when req_valid[i] & req_ready[i]; req_ready
    // is one-hot or zero and is derived only from req_valid and registered state.
    assign w_pick_req = (r_state == ST_OWNED) ? (req_valid & (NREQ'(1) << r_owner)) : req_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win)
    );

    assign w_xfer = |w_grant;
    assign w_op   = op_t'(req_op[2*w_win +: 2]);
    assign w_data = req_data[WIDTH*w_win +: WIDTH];
    assign w_lock = req_lock[w_win];
    assign w_lock_expired = (r_lock_cnt == LCW'(LOCK_MAX - 1));

    always_comb begin
        w_sum = '0;
        case (w_op)
            OP_INC:   w_sum = {1'b0, r_count} + (WIDTH+1)'(1);
            OP_ADD:   w_sum = {1'b0, r_count} + {1'b0, w_data};
            OP_LOAD:  w_sum = {1'b0, w_data};
            OP_CLEAR: w_sum = '0;
            default:  w_sum = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ARB;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_xfer) begin
                        r_ptr <= next_idx(w_win);
                        if (w_lock) begin
                            r_state    <= ST_OWNED;
                            r_owner    <= w_win;
                            r_lock_cnt <= '0;
                        end
                    end
                end
                ST_OWNED: begin
                    r_lock_cnt <= r_lock_cnt + LCW'(1);
                    // The expiry edge releases even if the owner asks to keep the lock.
                    if (w_lock_expired || (w_xfer && !w_lock)) begin
                        r_state <= ST_ARB;
                        r_ptr   <= next_idx(r_owner);
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_value <= '0;
            r_rsp_wrap  <= 1'b0;
        end else begin
            r_rsp_valid <= w_xfer;
            if (w_xfer) begin
                r_count     <= w_sum[WIDTH-1:0];
                r_rsp_id    <= w_win;
                r_rsp_value <= r_count;
                r_rsp_wrap  <= w_sum[WIDTH];
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_value = r_rsp_value;
    assign rsp_wrap  = r_rsp_wrap;
    assign count     = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Directed bench for shared_counter_arbiter: arbitration order, lock bounds,
// wrap-around arithmetic and asynchronous reset, with hand-computed expectations.
module tb_shared_counter_arbiter;
    import shared_counter_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [2*NREQ-1:0]       req_op = '0;
    logic [WIDTH*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]         req_lock = '0;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic [WIDTH-1:0]        rsp_value;
    logic                    rsp_wrap;
    logic [WIDTH-1:0]        count;
    state_t                  dbg_state;

    int checks   = 0;
    int failures = 0;

    shared_counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_value (rsp_value),
        .rsp_wrap  (rsp_wrap),
        .count     (count),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [WIDTH-1:0] d, input logic l);
        req_valid[i]           = v;
        req_op[2*i +: 2]       = op;
        req_data[WIDTH*i +: WIDTH] = d;
        req_lock[i]            = l;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        req_lock  = '0;
    endtask

    // Advance one clock; registered outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clear_reqs();
        do_reset();
        chk("reset_count", count, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_state", dbg_state, ST_ARB);
        chk("reset_ready", req_ready, 0);

        // Single INC from requester 2
        set_req(2, 1'b1, OP_INC, 0, 1'b0);
        #1 chk("t1_ready", req_ready, 4'b0100);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_value", rsp_value, 0);
        chk("t1_count", count, 1);
        clear_reqs();
        #1 chk("t1_ready_idle", req_ready, 0);
        tick();
        chk("t1_rsp_pulse", rsp_valid, 0);
        chk("t1_rsp_id_held", rsp_id, 2);

        // All four requesters hold INC: strict rotation, contiguous responses
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, OP_INC, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("t2_ready_%0d", k), req_ready, 4'b0001 << (k % 4));
            tick();
            chk($sformatf("t2_rsp_valid_%0d", k), rsp_valid, 1);
            chk($sformatf("t2_rsp_id_%0d", k), rsp_id, k % 4);
            chk($sformatf("t2_rsp_value_%0d", k), rsp_value, k);
        end
        chk("t2_count", count, 8);
        clear_reqs();

        // LOAD all-ones then ADD 2 from requester 1 wraps
        set_req(1, 1'b1, OP_LOAD, 32'hFFFF_FFFF, 1'b0);
        #1 chk("t3_ready_load", req_ready, 4'b0010);
        tick();
        chk("t3_load_value", rsp_value, 8);
        chk("t3_load_wrap", rsp_wrap, 0);
        chk("t3_load_count", count, 32'hFFFF_FFFF);
        set_req(1, 1'b1, OP_ADD, 2, 1'b0);
        tick();
        chk("t3_add_valid", rsp_valid, 1);
        chk("t3_add_value", rsp_value, 32'hFFFF_FFFF);
        chk("t3_add_wrap", rsp_wrap, 1);
        chk("t3_add_count", count, 1);
        set_req(1, 1'b1, OP_CLEAR, 0, 1'b0);
        tick();
        chk("t3_clear_wrap", rsp_wrap, 0);
        chk("t3_clear_count", count, 0);
        clear_reqs();

        // Lock by requester 0 is held for exactly LOCK_MAX owned cycles
        do_reset();
        set_req(0, 1'b1, OP_INC, 0, 1'b1);
        for (int r = 1; r < NREQ; r++) set_req(r, 1'b1, OP_INC, 0, 1'b0);
        #1 chk("t4_lock_grant", req_ready, 4'b0001);
        tick();
        chk("t4_state_owned", dbg_state, ST_OWNED);
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("t4_owned_ready_%0d", k), req_ready, 4'b0001);
            tick();
        end
        chk("t4_state_released", dbg_state, ST_ARB);
        chk("t4_count_locked", count, 9);
        #1 chk("t4_next_grant", req_ready, 4'b0010);
        tick();
        chk("t4_next_rsp_id", rsp_id, 1);
        chk("t4_count_after", count, 10);
        clear_reqs();

        // Owner 2 releases early with CLEAR in lock cycle 3
        do_reset();
        set_req(2, 1'b1, OP_INC, 0, 1'b1);
        #1 chk("t5_lock_grant", req_ready, 4'b0100);
        tick();
        set_req(2, 1'b0, OP_INC, 0, 1'b0);
        set_req(0, 1'b1, OP_INC, 0, 1'b0);
        set_req(1, 1'b1, OP_INC, 0, 1'b0);
        set_req(3, 1'b1, OP_INC, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("t5_wait_ready_%0d", k), req_ready, 0);
            tick();
        end
        set_req(2, 1'b1, OP_CLEAR, 0, 1'b0);
        #1 chk("t5_clear_grant", req_ready, 4'b0100);
        tick();
        chk("t5_count", count, 0);
        chk("t5_rsp_value", rsp_value, 1);
        chk("t5_state_arb", dbg_state, ST_ARB);
        #1 chk("t5_next_grant", req_ready, 4'b1000);
        clear_reqs();
        tick();

        // Reset asserted while owned with a response in flight
        do_reset();
        set_req(1, 1'b1, OP_LOAD, 4, 1'b0);
        tick();
        set_req(1, 1'b1, OP_INC, 0, 1'b1);
        tick();
        chk("t6_pre_count", count, 5);
        chk("t6_pre_rsp_valid", rsp_valid, 1);
        chk("t6_pre_state", dbg_state, ST_OWNED);
        clear_reqs();
        reset = 1'b1;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_rsp_id", rsp_id, 0);
        chk("t6_rst_rsp_value", rsp_value, 0);
        chk("t6_rst_state", dbg_state, ST_ARB);
        tick();
        reset = 1'b0;
        set_req(3, 1'b1, OP_INC, 0, 1'b0);
        #1 chk("t6_post_grant", req_ready, 4'b1000);
        tick();
        chk("t6_post_rsp_id", rsp_id, 3);
        chk("t6_post_count", count, 1);
        clear_reqs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_counter_arbiter.md
# shared_counter_arbiter

Arbitrates a single shared WIDTH-bit counter register between NREQ requesters. Each requester issues INC/ADD/LOAD/CLEAR commands over a valid/ready handshake. A round-robin scheduler with an optional bounded lock decides which requester gets the counter each cycle. Every accepted command returns the pre-operation count one cycle later. It sits between the counter datapath and the blocks that previously drove the counter directly.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8)
- WIDTH, 32: counter width
- LOCK_MAX, 8: maximum consecutive cycles one owner may hold a lock

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  command valid, one bit per requester
- req_op  in  2*NREQ  opcode per requester, slice [2i+1:2i]
- req_data  in  WIDTH*NREQ  operand per requester, slice [WIDTH*i +: WIDTH]
- req_lock  in  NREQ  keep ownership after this transfer
- req_ready  out  NREQ  grant, one-hot or zero
- rsp_valid  out  1  response strobe
- rsp_id  out  $clog2(NREQ)  requester index of the response
- rsp_value  out  WIDTH  count before the operation
- rsp_wrap  out  1  the INC/ADD wrapped past 2^WIDTH-1
- count  out  WIDTH  current counter value

## Operation

- Opcodes: 00 INC (+1), 01 ADD (+req_data), 10 LOAD (=req_data), 11 CLEAR (=0). Arithmetic is modulo 2^WIDTH. rsp_wrap is the carry-out and is always 0 for LOAD and CLEAR.
- Transfer occurs on req_valid[i] & req_ready[i]. At most one transfer per cycle.
- FSM state ARB:
  - Grant the first valid requester searching upward from ptr, with wrap-around.
  - After a transfer, ptr becomes (winner+1) mod NREQ.
  - A transfer with req_lock=1 moves to OWNED with owner=winner and lock_cnt=0.
- FSM state OWNED:
  - Only owner may be granted; the grant is req_valid[owner]. Other requesters wait, with req_ready=0.
  - lock_cnt increments every OWNED cycle, whether or not a transfer occurs.
  - An owner transfer with req_lock=0 returns to ARB.
  - If lock_cnt==LOCK_MAX-1, return to ARB at that edge regardless of req_lock. A transfer in that cycle still completes.
  - On every exit from OWNED, ptr becomes (owner+1) mod NREQ.
- req_ready depends combinationally on req_valid and registered state only, never on req_op or req_data.
- Reset values:
  - count=0, ptr=0, state=ARB, owner=0, lock_cnt=0.
  - rsp_valid=0, rsp_id=0, rsp_value=0, rsp_wrap=0.
  - Reset asserted mid-lock or mid-response clears all state immediately, and any in-flight response is lost.

## Timing

- Grant is same-cycle: req_ready is valid in the cycle req_valid is presented.
- count updates at the clock edge that ends the transfer cycle.
- rsp_valid pulses for exactly one cycle, the cycle after the transfer. rsp_value, rsp_id and rsp_wrap are held until the next response.
- Back-to-back transfers are allowed: throughput is 1 command/cycle and responses are contiguous.
- A requester that deasserts valid before being granted loses nothing. It simply re-enters arbitration.
- In OWNED, the edge at lock_cnt==LOCK_MAX-1 makes at most LOCK_MAX owner grants possible per lock, counted after the locking transfer.

## Structure

- Package shared_counter_pkg holds:
  - the op_t enum (OP_INC, OP_ADD, OP_LOAD, OP_CLEAR);
  - the state_t enum (ST_ARB, ST_OWNED);
  - default WIDTH/NREQ/LOCK_MAX constants.
- Sub-module rr_pick: combinational round-robin picker. It takes a NREQ request vector and a ptr, and outputs a one-hot grant plus the winning index. It is instantiated once.
- The counter update and the response registers live in the top module, in a single always_ff block.

## Test plan

- Reset then single INC from req 2: rsp_valid next cycle with rsp_id=2, rsp_value=0. count=1 afterwards.
- All 4 requesters hold valid INC for 8 cycles from reset: grants cycle 0,1,2,3,0,1,2,3, count=8, responses contiguous.
- LOAD 0xFFFFFFFF then ADD 2 from req 1: the second response has rsp_value=0xFFFFFFFF and rsp_wrap=1. count=1.
- Req 0 transfers INC with lock=1 while reqs 1–3 hold valid:
  - only req 0 is granted for the next 8 cycles (LOCK_MAX=8);
  - then a forced release, after which the next grant goes to req 1.
- Locked owner transfers CLEAR with lock=0 in lock cycle 3: count=0, state returns to ARB, and the next grant goes to owner+1.
- Assert reset while in OWNED with count=5 and rsp_valid=1:
  - all outputs go to 0 immediately;
  - after release, a request from req 3 is granted in ARB.
